// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: grant one-hot indices and arbiter FSM states
package mem_arb_pkg;
  localparam int GIC = 0;
  localparam int GDF = 1;
  localparam int GWB = 2;
  localparam int GUC = 3;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
endpackage

// File: rtl/mem_arb_prio.sv
// arb_prio: fixed priority WB > DF > UC > IC, IC forced once it has been starved STARVE_MAX times
module arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic [3:0] req,
  input  logic [3:0] starve,
  output logic [3:0] pick
);
  always_comb
    pick = (req[GIC] && starve == 4'(STARVE_MAX)) ? 4'(1 << GIC) :
           req[GWB] ? 4'(1 << GWB) :
           req[GDF] ? 4'(1 << GDF) :
           req[GUC] ? 4'(1 << GUC) :
           req[GIC] ? 4'(1 << GIC) : 4'd0;
endmodule

// File: rtl/mem_arb.sv
// mem_arb: single-port memory arbiter and burst sequencer for IC/DF/WB/UC requesters
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int IC_BEATS   = 4,
  parameter int DC_BEATS   = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  input  logic        df_req,
  input  logic [31:0] df_addr,
  input  logic        wb_req,
  input  logic [31:0] wb_addr,
  input  logic [63:0] wb_wdata,
  input  logic        uc_req,
  input  logic        uc_we,
  input  logic [31:0] uc_addr,
  input  logic [2:0]  uc_sz,
  input  logic [63:0] uc_wdata,
  output logic [3:0]  gnt,
  output logic [63:0] rdata,
  output logic        rvalid,
  output logic        wnext,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_len,
  output logic [2:0]  mem_sz,
  input  logic        mem_ack,
  output logic [63:0] mem_wdata,
  input  logic        mem_wready,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        mem_err
);
  state_t     state;
  logic [3:0] cnt;
  logic [3:0] starve;
  logic [3:0] pick;
  logic       err_f;
  logic       beat;
  arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .req   ({uc_req, wb_req, df_req, ic_req}),
    .starve(starve),
    .pick  (pick)
  );
  assign beat      = state == DATA && (mem_we ? mem_wready : mem_rvalid);
  assign rvalid    = state == DATA && !mem_we && mem_rvalid;
  assign wnext     = state == DATA && mem_we && mem_wready;
  assign rdata     = mem_rdata;
  assign mem_wdata = gnt[GWB] ? wb_wdata : uc_wdata;
  // err_f is only ever set on the way into DONE, so it doubles as the err output
  assign err       = err_f;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      gnt      <= '0;
      cnt      <= '0;
      starve   <= '0;
      err_f    <= 1'b0;
      done     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_len  <= '0;
      mem_sz   <= '0;
    end else begin
      done   <= 1'b0;
      starve <= !ic_req ? 4'd0 :
                (state == IDLE && |pick) ? (pick[GIC] ? 4'd0 :
                                            starve == 4'(STARVE_MAX) ? starve : starve + 4'd1) :
                starve;
      case (state)
        IDLE:
          if (|pick) begin
            state    <= ADDR;
            gnt      <= pick;
            mem_req  <= 1'b1;
            cnt      <= '0;
            mem_addr <= pick[GWB] ? wb_addr : pick[GDF] ? df_addr : pick[GUC] ? uc_addr : ic_addr;
            mem_we   <= pick[GWB] | (pick[GUC] & uc_we);
            mem_len  <= pick[GIC] ? 4'(IC_BEATS - 1) : pick[GUC] ? 4'd0 : 4'(DC_BEATS - 1);
            mem_sz   <= pick[GUC] ? uc_sz : 3'd7;
          end
        ADDR:
          if (mem_ack) begin
            state   <= DATA;
            mem_req <= 1'b0;
          end
        DATA:
          if (beat) begin
            cnt <= cnt + 4'd1;
            if (mem_err || cnt == mem_len) begin
              state <= DONE;
              done  <= 1'b1;
              err_f <= mem_err;
            end
          end
        DONE: begin
          state <= IDLE;
          gnt   <= '0;
          err_f <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scenario tasks plus randomized arbitration against a rule-level reference model
module tb_mem_arb;
  logic        clk = 1'b0;
  logic        resetn;
  logic        ic_req, df_req, wb_req, uc_req, uc_we;
  logic [31:0] ic_addr, df_addr, wb_addr, uc_addr;
  logic [63:0] wb_wdata, uc_wdata;
  logic [2:0]  uc_sz;
  logic [3:0]  gnt;
  logic [63:0] rdata;
  logic        rvalid, wnext, done, err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_len;
  logic [2:0]  mem_sz;
  logic        mem_ack, mem_wready, mem_rvalid, mem_err;
  logic [63:0] mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [3:0]  o_gnt, o_len, o_gnt_after;
  logic [31:0] o_addr;
  logic        o_we, o_err, o_done2;
  logic [2:0]  o_sz;
  int          o_req_cyc, o_lat;
  bit          o_to;
  logic [63:0] rdq[$];
  logic [63:0] wdq[$];
  logic [63:0] wb_base;

  mem_arb dut (
    .clk(clk), .resetn(resetn),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .df_req(df_req), .df_addr(df_addr),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .uc_req(uc_req), .uc_we(uc_we), .uc_addr(uc_addr), .uc_sz(uc_sz), .uc_wdata(uc_wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .wnext(wnext), .done(done), .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_len(mem_len), .mem_sz(mem_sz),
    .mem_ack(mem_ack), .mem_wdata(mem_wdata), .mem_wready(mem_wready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Plays the bus slave for one transaction and records what the arbiter did; no judging here.
  task automatic bus_xact(input int ack_dly, input int err_beat, input logic [63:0] base, input bit rw);
    int t, b, last_t;
    bit go, adv;
    rdq.delete();
    wdq.delete();
    o_req_cyc = 0;
    t = 0;
    b = 0;
    last_t = 0;
    adv = 0;
    while (!mem_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    o_gnt = gnt; o_addr = mem_addr; o_we = mem_we; o_len = mem_len; o_sz = mem_sz;
    while (mem_req && o_req_cyc < 60) begin
      o_req_cyc++;
      mem_ack = o_req_cyc > ack_dly;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    t = 0;
    while (!done && t < 100) begin
      if (adv) wb_wdata = wb_wdata + 64'd1;
      adv = 0;
      go = !rw || $urandom_range(0, 2) != 0;
      mem_rvalid = go && !o_we;
      mem_wready = go && o_we;
      mem_rdata  = base + 64'(b);
      mem_err    = go && b == err_beat;
      #1;
      if (rvalid) rdq.push_back(rdata);
      if (wnext) begin
        wdq.push_back(mem_wdata);
        adv = gnt[2];
      end
      if (go) begin
        b++;
        last_t = t;
      end
      @(negedge clk);
      t++;
    end
    mem_rvalid = 1'b0; mem_wready = 1'b0; mem_err = 1'b0;
    o_to  = !done;
    o_lat = t - last_t;
    o_err = err;
    if (gnt[0]) ic_req = 1'b0;
    if (gnt[1]) df_req = 1'b0;
    if (gnt[2]) wb_req = 1'b0;
    if (gnt[3]) uc_req = 1'b0;
    @(negedge clk);
    o_gnt_after = gnt;
    o_done2 = done;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    ic_req = 1'b1; df_req = 1'b1; wb_req = 1'b1; uc_req = 1'b1;
    ic_addr = '0; df_addr = '0; wb_addr = '0; uc_addr = '0;
    uc_we = 1'b0; uc_sz = '0; wb_wdata = '0; uc_wdata = '0;
    mem_ack = 1'b1; mem_wready = 1'b1; mem_rvalid = 1'b1; mem_err = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if ({rvalid, wnext} !== 2'b00) begin errors++; $display("FAIL reset_rvalid_wnext: got %b want 00", {rvalid, wnext}); end
    checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b want 00", {done, err}); end
    ic_req = 1'b0; df_req = 1'b0; wb_req = 1'b0; uc_req = 1'b0;
    mem_ack = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ic_fill;
    bit ok;
    ic_addr = 32'h0000_1000;
    ic_req = 1'b1;
    bus_xact(0, -1, 64'hA0, 0);
    ok = rdq.size() == 4;
    foreach (rdq[i]) if (rdq[i] !== 64'hA0 + 64'(i)) ok = 0;
    checks++; if (o_gnt !== 4'b0001) begin errors++; $display("FAIL ic_gnt: got %b want 0001", o_gnt); end
    checks++; if (o_addr !== 32'h1000 || o_we !== 1'b0) begin errors++; $display("FAIL ic_addr_we: got %h/%b want 00001000/0", o_addr, o_we); end
    checks++; if (o_len !== 4'd3 || o_sz !== 3'd7) begin errors++; $display("FAIL ic_len_sz: got %0d/%0d want 3/7", o_len, o_sz); end
    checks++; if (o_req_cyc != 1) begin errors++; $display("FAIL ic_req_cycles: got %0d want 1", o_req_cyc); end
    checks++; if (!ok) begin errors++; $display("FAIL ic_rdata: got %0d beats first %h want 4 beats A0..A3", rdq.size(), rdq.size() ? rdq[0] : 64'hx); end
    checks++; if (o_to || o_lat != 1 || o_err !== 1'b0) begin errors++; $display("FAIL ic_done: timeout=%0d lat=%0d err=%b want 0/1/0", o_to, o_lat, o_err); end
    checks++; if (o_done2 !== 1'b0 || o_gnt_after !== 4'b0) begin errors++; $display("FAIL ic_after_done: done=%b gnt=%b want 0/0000", o_done2, o_gnt_after); end
  endtask

  task automatic test_wb_ic;
    bit ok;
    wb_addr = 32'h0000_2010; wb_base = 64'h5000; wb_wdata = wb_base;
    ic_addr = 32'h0000_3000;
    wb_req = 1'b1; ic_req = 1'b1;
    bus_xact(0, -1, 64'h0, 0);
    ok = wdq.size() == 2;
    foreach (wdq[i]) if (wdq[i] !== wb_base + 64'(i)) ok = 0;
    checks++; if (o_gnt !== 4'b0100 || o_we !== 1'b1 || o_len !== 4'd1) begin errors++; $display("FAIL wb_first: gnt=%b we=%b len=%0d want 0100/1/1", o_gnt, o_we, o_len); end
    checks++; if (!ok || rdq.size() != 0) begin errors++; $display("FAIL wb_wnext: got %0d writes %0d reads want 2 writes 5000,5001", wdq.size(), rdq.size()); end
    bus_xact(1, -1, 64'hB0, 1);
    checks++; if (o_gnt !== 4'b0001 || o_addr !== 32'h3000 || rdq.size() != 4) begin errors++; $display("FAIL ic_after_wb: gnt=%b addr=%h beats=%0d want 0001/00003000/4", o_gnt, o_addr, rdq.size()); end
  endtask

  task automatic test_starve;
    logic [3:0] exp;
    ic_req = 1'b1; df_req = 1'b1; wb_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_xact(0, -1, 64'h0, 1);
      exp = i < 3 ? 4'b0100 : 4'b0001;
      checks++; if (o_gnt !== exp) begin errors++; $display("FAIL starve_grant%0d: got %b want %b", i, o_gnt, exp); end
      if (i < 3) wb_req = 1'b1;
    end
    wb_req = 1'b0; df_req = 1'b0; ic_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_uc_delay;
    uc_addr = 32'h0000_4004; uc_we = 1'b0; uc_sz = 3'd3; uc_req = 1'b1;
    bus_xact(5, -1, 64'hC0, 0);
    checks++; if (o_req_cyc != 6) begin errors++; $display("FAIL uc_req_cycles: got %0d want 6", o_req_cyc); end
    checks++; if (o_gnt !== 4'b1000 || o_len !== 4'd0 || o_sz !== 3'd3) begin errors++; $display("FAIL uc_fields: gnt=%b len=%0d sz=%0d want 1000/0/3", o_gnt, o_len, o_sz); end
    checks++; if (rdq.size() != 1 || (rdq.size() == 1 && rdq[0] !== 64'hC0)) begin errors++; $display("FAIL uc_rdata: got %0d beats want 1 beat C0", rdq.size()); end
    checks++; if (o_to || o_lat != 1 || o_err !== 1'b0) begin errors++; $display("FAIL uc_done: timeout=%0d lat=%0d err=%b want 0/1/0", o_to, o_lat, o_err); end
  endtask

  task automatic test_err;
    df_addr = 32'h0000_5020; df_req = 1'b1;
    bus_xact(0, 1, 64'hD0, 0);
    checks++; if (o_gnt !== 4'b0010 || o_to || o_err !== 1'b1) begin errors++; $display("FAIL df_err: gnt=%b timeout=%0d err=%b want 0010/0/1", o_gnt, o_to, o_err); end
    checks++; if (o_gnt_after !== 4'b0 || o_done2 !== 1'b0) begin errors++; $display("FAIL df_err_after: gnt=%b done=%b want 0000/0", o_gnt_after, o_done2); end
    ic_addr = 32'h0000_8000; ic_req = 1'b1;
    bus_xact(0, 1, 64'hF0, 0);
    checks++; if (rdq.size() != 2 || o_err !== 1'b1 || o_lat != 1) begin errors++; $display("FAIL ic_err_truncate: beats=%0d err=%b lat=%0d want 2/1/1", rdq.size(), o_err, o_lat); end
  endtask

  task automatic test_reset_mid;
    int t = 0;
    ic_addr = 32'h0000_6000; ic_req = 1'b1;
    while (!mem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 64'(i);
      @(negedge clk);
    end
    mem_rdata = 64'd2; resetn = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL midreset_idle: gnt=%b mem_req=%b want 0000/0", gnt, mem_req); end
    checks++; if (done !== 1'b0 || rvalid !== 1'b0) begin errors++; $display("FAIL midreset_quiet: done=%b rvalid=%b want 0/0", done, rvalid); end
    resetn = 1'b1; mem_rvalid = 1'b0; ic_req = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_nodone: got %b want 0", done); end
    df_addr = 32'h0000_7000; df_req = 1'b1;
    bus_xact(0, -1, 64'hE0, 0);
    checks++; if (o_gnt !== 4'b0010 || o_addr !== 32'h7000 || rdq.size() != 2 || o_to || o_err !== 1'b0) begin errors++; $display("FAIL midreset_df: gnt=%b addr=%h beats=%0d timeout=%0d err=%b want 0010/00007000/2/0/0", o_gnt, o_addr, rdq.size(), o_to, o_err); end
  endtask

  // Reference: pending requests are held until served; arbitration follows the priority/starvation rules.
  task automatic test_random;
    logic [3:0] pend = '0;
    int s = 0;
    int w, e_len, eb, nb;
    logic [31:0] e_addr;
    logic e_we;
    logic [2:0] e_sz;
    logic [63:0] base, ev;
    bit ok;
    for (int r = 0; r < 40; r++) begin
      if (!pend[0] && $urandom_range(0, 2) == 0) begin pend[0] = 1'b1; ic_addr = $urandom & 32'hffff_ffe0; end
      if (!pend[1] && $urandom_range(0, 2) == 0) begin pend[1] = 1'b1; df_addr = $urandom & 32'hffff_fff0; end
      if (!pend[2] && $urandom_range(0, 2) == 0) begin
        pend[2] = 1'b1; wb_addr = $urandom & 32'hffff_fff0; wb_base = {$urandom, $urandom}; wb_wdata = wb_base;
      end
      if (!pend[3] && $urandom_range(0, 2) == 0) begin
        pend[3] = 1'b1; uc_addr = $urandom; uc_we = 1'($urandom); uc_sz = 3'($urandom); uc_wdata = {$urandom, $urandom};
      end
      if (pend == 4'b0) begin pend[1] = 1'b1; df_addr = $urandom & 32'hffff_fff0; end
      {uc_req, wb_req, df_req, ic_req} = pend;
      w = (pend[0] && s == 3) ? 0 : pend[2] ? 2 : pend[1] ? 1 : pend[3] ? 3 : 0;
      e_addr = w == 0 ? ic_addr : w == 1 ? df_addr : w == 2 ? wb_addr : uc_addr;
      e_we = w == 2 || (w == 3 && uc_we);
      e_len = w == 0 ? 3 : w == 3 ? 0 : 1;
      e_sz = w == 3 ? uc_sz : 3'd7;
      eb = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, 3)) : -1;
      base = {$urandom, $urandom};
      bus_xact(int'($urandom_range(0, 3)), eb, base, 1);
      nb = (eb >= 0 && eb < e_len) ? eb + 1 : e_len + 1;
      ok = e_we ? (wdq.size() == nb && rdq.size() == 0) : (rdq.size() == nb && wdq.size() == 0);
      for (int i = 0; i < nb && ok; i++) begin
        ev = e_we ? (w == 2 ? wb_base + 64'(i) : uc_wdata) : base + 64'(i);
        if ((e_we ? wdq[i] : rdq[i]) !== ev) ok = 0;
      end
      checks++; if (o_gnt !== 4'(1 << w)) begin errors++; $display("FAIL rnd%0d_gnt: got %b want %b", r, o_gnt, 4'(1 << w)); end
      checks++; if (o_addr !== e_addr || o_we !== e_we) begin errors++; $display("FAIL rnd%0d_addr_we: got %h/%b want %h/%b", r, o_addr, o_we, e_addr, e_we); end
      checks++; if (o_len !== 4'(e_len) || o_sz !== e_sz) begin errors++; $display("FAIL rnd%0d_len_sz: got %0d/%0d want %0d/%0d", r, o_len, o_sz, e_len, e_sz); end
      checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_data: got %0d rd %0d wr want %0d beats", r, rdq.size(), wdq.size(), nb); end
      checks++; if (o_to || o_lat != 1 || o_err !== (eb >= 0 && eb <= e_len)) begin errors++; $display("FAIL rnd%0d_done: timeout=%0d lat=%0d err=%b want 0/1/%b", r, o_to, o_lat, o_err, eb >= 0 && eb <= e_len); end
      checks++; if (o_gnt_after !== 4'b0 || o_done2 !== 1'b0) begin errors++; $display("FAIL rnd%0d_after: gnt=%b done=%b want 0000/0", r, o_gnt_after, o_done2); end
      s = pend[0] ? (w == 0 ? 0 : (s < 3 ? s + 1 : 3)) : 0;
      pend[w] = 1'b0;
    end
    {uc_req, wb_req, df_req, ic_req} = 4'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_ic_fill;
    test_wb_ic;
    test_starve;
    test_uc_delay;
    test_err;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Single-port system-memory arbiter and burst sequencer, between the CPU caches and the external bus.
- Shares one 64-bit memory port among four requesters:
  - instruction-cache line fill (IC)
  - data-cache line fill (DF)
  - data-cache writeback (WB)
  - uncached single-beat access (UC)
- Serialises their transactions, counts beats, routes read data and write-data handshakes, and reports completion or bus error to the winner.

Parameters:
- IC_BEATS, 4, 64-bit beats per icache line fill (32 B).
- DC_BEATS, 2, 64-bit beats per dcache line fill or writeback (16 B).
- STARVE_MAX, 3, consecutive non-IC grants allowed while IC is waiting before IC is forced to win.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- ic_req  in  1  IC fill request; held until ic_done.
- ic_addr  in  32  IC line physical address (line-aligned).
- df_req  in  1  dcache fill request.
- df_addr  in  32  dcache fill physical address.
- wb_req  in  1  dcache writeback request.
- wb_addr  in  32  writeback physical address.
- wb_wdata  in  64  current writeback beat.
- uc_req  in  1  uncached request.
- uc_we  in  1  uncached write (1) / read (0).
- uc_addr  in  32  uncached physical address.
- uc_sz  in  3  byte count minus 1 (0..7).
- uc_wdata  in  64  uncached write data.
- gnt  out  4  one-hot grant {UC,WB,DF,IC}; valid from ADDR through DONE.
- rdata  out  64  read beat, broadcast to all requesters.
- rvalid  out  1  read beat valid for the granted requester.
- wnext  out  1  write beat consumed; the requester advances its data.
- done  out  1  one-cycle completion pulse to the granted requester.
- err  out  1  qualifies done: bus error occurred.
- mem_req  out  1  bus address-phase request.
- mem_addr  out  32  bus address.
- mem_we  out  1  bus write.
- mem_len  out  4  beats minus 1.
- mem_sz  out  3  byte count minus 1 for single-beat access; 7 for bursts.
- mem_ack  in  1  address phase accepted.
- mem_wdata  out  64  write beat.
- mem_wready  in  1  write beat accepted.
- mem_rdata  in  64  read beat.
- mem_rvalid  in  1  read beat valid.
- mem_err  in  1  bus error, valid with mem_rvalid or mem_wready.

Behaviour:
- Reset (resetn=0 at an edge):
  - State goes to IDLE; beat counter and starve counter go to 0.
  - gnt, mem_req, rvalid, wnext, done and err all go to 0.
  - Reset mid-burst abandons the transaction silently; no done pulse is issued.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If any request is pending, select the winner, latch addr/we/len/sz, set gnt, go to ADDR on the next cycle.
  - Priority: WB > DF > UC > IC.
  - Exception: if starve_cnt == STARVE_MAX and ic_req=1, IC wins.
- Starve counter:
  - Increments on each non-IC grant while ic_req=1, saturating at STARVE_MAX.
  - Clears on an IC grant or when ic_req=0.
- ADDR:
  - mem_req=1 with latched fields; remain in ADDR until mem_ack=1, then go to DATA.
  - mem_len is IC_BEATS-1 for IC, DC_BEATS-1 for DF/WB, 0 for UC.
- DATA, reads:
  - rvalid = mem_rvalid (combinational pass-through); rdata = mem_rdata.
  - Beat counter increments per mem_rvalid.
- DATA, writes:
  - mem_wdata = wb_wdata (WB) or uc_wdata (UC).
  - wnext = mem_wready; beat counter increments per mem_wready.
- DATA exit:
  - Leave DATA when the counter reaches mem_len on an accepted beat.
  - mem_err=1 on any beat sets a sticky err_f and terminates the burst immediately.
  - Either way, go to DONE.
- DONE:
  - done=1 and err=err_f for exactly one cycle; gnt still held.
  - Next cycle: gnt=0, err_f cleared, go to IDLE.
  - Requesters drop req in the same cycle they see done. A req still high in IDLE one cycle later is treated as a new request.
- Minimum transaction: 4 cycles (IDLE-ADDR-DATA-DONE) with zero bus wait.
- A request deasserted while in ADDR/DATA is ignored; the transaction completes normally.
- Simultaneous requests are resolved only in IDLE; no preemption.

Decomposition:
- Shared package/include (with cpu constants): grant one-hot indices GIC=0, GDF=1, GWB=2, GUC=3; FSM state encodings.
- One natural sub-module: arb_prio (combinational fixed-priority pick plus starvation override, one-hot out). Beat counter and FSM stay in mem_arb.

Test Plan:
- Reset mid-burst: assert resetn=0 during beat 2 of an IC fill -> next cycle gnt=0, mem_req=0, no done; a subsequent df_req is served normally.
- Single IC fill, addr 0x00001000, zero-wait bus returning beats 0xA0..0xA3 -> mem_len=3, four rvalid pulses carrying those values, done=1 err=0 exactly one cycle after the last beat.
- wb_req and ic_req raised in the same cycle -> WB granted first (mem_we=1, mem_len=1, two wnext pulses); IC granted afterwards.
- Continuous df_req/wb_req pressure with ic_req held -> after 3 non-IC grants, IC is granted on the 4th arbitration.
- UC read with uc_sz=3, mem_ack delayed 5 cycles -> mem_req held for 6 cycles, mem_len=0, mem_sz=3, one rvalid, then done.
- mem_err on beat 1 of a DF fill -> burst terminated, done=1 with err=1, gnt cleared the following cycle.
